cla32_bist: RTL and testbench

Self-checking stimulus/response engine for the 32-bit carry-lookahead adder: the hardware counterpart of the bench vector flow. On start it drives N operand vectors into a combinational `cla32` instance, computes the golden 33-bit result internally, compares the adder's sum/carry one cycle later, and reports error count, first failing index and pass/fail. It sits beside the adder in the datapath test wrapper and needs no vector files.

---
 rtl/cla32_bist.sv | 169 ++++++++++++++++
 tb/tb_cla32_bist.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/cla32_bist.sv
// Stimulus/response engine for the 32-bit CLA: drives N operand vectors (two fixed, the rest
// from an LFSR) into an external adder and checks each result against an internal golden sum.
module cla32_bist #(
    parameter int          N    = 100,
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        i_start,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic        o_c,
    input  logic [31:0] i_sum,
    input  logic        i_c,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [15:0] o_err,
    output logic [15:0] o_first,
    output logic [15:0] o_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(N - 1);
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
    localparam logic [15:0] NONE     = 16'hFFFF;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        c_q, c_d;
    logic [32:0] gold_q, gold_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] err_q, err_d;
    logic [15:0] first_q, first_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    logic [31:0] vec_a, vec_b, lfsr_mid;
    logic        vec_c;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        gold_d   = gold_q;
        lfsr_d   = lfsr_q;
        idx_d    = idx_q;
        err_d    = err_q;
        first_d  = first_q;
        vec_a    = 32'h0;
        vec_b    = 32'h0;
        vec_c    = 1'b0;
        lfsr_mid = 32'h0;

        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    state_d = DRIVE;
                    idx_d   = 16'h0;
                    err_d   = 16'h0;
                    first_d = NONE;
                    lfsr_d  = SEED_EFF;
                end
            end
            DRIVE: begin
                // The LFSR advances twice per random vector and not at all for the fixed ones
                if (idx_q == 16'd0) begin
                    vec_a = 32'hFFFF_FFFF;
                    vec_b = 32'h0;
                    vec_c = 1'b1;
                end else if (idx_q == 16'd1) begin
                    vec_a = 32'hFFFF_FFFF;
                    vec_b = 32'hFFFF_FFFF;
                    vec_c = 1'b1;
                end else begin
                    vec_a    = lfsr_q;
                    lfsr_mid = lfsr_step(lfsr_q);
                    vec_b    = lfsr_mid;
                    lfsr_d   = lfsr_step(lfsr_mid);
                    vec_c    = vec_a[0] ^ vec_b[31];
                end
                a_d     = vec_a;
                b_d     = vec_b;
                c_d     = vec_c;
                gold_d  = {1'b0, vec_a} + {1'b0, vec_b} + {32'h0, vec_c};
                state_d = CHECK;
            end
            CHECK: begin
                if ({i_c, i_sum} != gold_q) begin
                    if (err_q != 16'hFFFF) begin
                        err_d = err_q + 16'd1;
                    end
                    if (first_q == NONE) begin
                        first_d = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 16'd1;
                    state_d = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status flags are registered off the current state, so they trail the FSM by one edge
    always_comb begin
        busy_d = (state_q == DRIVE) || (state_q == CHECK);
        done_d = (state_q == DONE);
        pass_d = (state_q == DONE) && (err_q == 16'h0);
    end

    always_ff @(posedge CLK) begin
        if (RSTb) begin
            state_q <= IDLE;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            c_q     <= 1'b0;
            gold_q  <= 33'h0;
            lfsr_q  <= SEED_EFF;
            idx_q   <= 16'h0;
            err_q   <= 16'h0;
            first_q <= NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            gold_q  <= gold_d;
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign o_a     = a_q;
    assign o_b     = b_q;
    assign o_c     = c_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_pass  = pass_q;
    assign o_err   = err_q;
    assign o_first = first_q;
    assign o_idx   = idx_q;

endmodule

// File: tb/tb_cla32_bist.sv
// Bench for cla32_bist: a behavioural adder with selectable faults beside the engine,
// checked against hand-computed operand vectors and error counts.
module tb_cla32_bist;

    localparam int NV = 5;

    logic        CLK;
    logic        RSTb;
    logic        i_start;
    logic [31:0] o_a, o_b, i_sum;
    logic        o_c, i_c;
    logic        o_busy, o_done, o_pass;
    logic [15:0] o_err, o_first, o_idx;

    int          faultMode;
    logic [32:0] addRes;
    int          total;
    int          bad;

    // SEED=0 must behave exactly like SEED=1, so these vectors come from seed 1 by hand
    logic [31:0] expA [0:NV-1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0006, 32'h0000_001B};
    logic [31:0] expB [0:NV-1] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_000D, 32'h0000_0036};
    logic        expC [0:NV-1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    cla32_bist #(.N(NV), .SEED(32'h0000_0000)) u_dut (
        .CLK     (CLK),
        .RSTb    (RSTb),
        .i_start (i_start),
        .o_a     (o_a),
        .o_b     (o_b),
        .o_c     (o_c),
        .i_sum   (i_sum),
        .i_c     (i_c),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_pass  (o_pass),
        .o_err   (o_err),
        .o_first (o_first),
        .o_idx   (o_idx)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Adder under test: fault 1 sticks sum bit 0 low, fault 2 inverts the carry-out
    assign addRes = {1'b0, o_a} + {1'b0, o_b} + {32'h0, o_c};
    assign i_sum  = (faultMode == 1) ? {addRes[31:1], 1'b0} : addRes[31:0];
    assign i_c    = (faultMode == 2) ? ~addRes[32] : addRes[32];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_a"}, 64'(o_a), 64'h0);
        checkOutput({tag, "_b"}, 64'(o_b), 64'h0);
        checkOutput({tag, "_c"}, 64'(o_c), 64'h0);
        checkOutput({tag, "_busy"}, 64'(o_busy), 64'h0);
        checkOutput({tag, "_done"}, 64'(o_done), 64'h0);
        checkOutput({tag, "_pass"}, 64'(o_pass), 64'h0);
        checkOutput({tag, "_err"}, 64'(o_err), 64'h0);
        checkOutput({tag, "_first"}, 64'(o_first), 64'hFFFF);
        checkOutput({tag, "_idx"}, 64'(o_idx), 64'h0);
    endtask

    // One full run: checks every driven vector, the done edge count and the final status
    task automatic applyStimulus(input string tag, input int fault, input logic [15:0] expErr,
                                 input logic [15:0] expFirst, input bit pokeBusy);
        int edges;
        faultMode = fault;
        @(negedge CLK);
        i_start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        i_start = 1'b0;
        for (int k = 0; k < NV; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            checkOutput($sformatf("%s_a%0d", tag, k), 64'(o_a), 64'(expA[k]));
            checkOutput($sformatf("%s_b%0d", tag, k), 64'(o_b), 64'(expB[k]));
            checkOutput($sformatf("%s_c%0d", tag, k), 64'(o_c), 64'(expC[k]));
            checkOutput($sformatf("%s_idx%0d", tag, k), 64'(o_idx), 64'(k));
            checkOutput($sformatf("%s_busy%0d", tag, k), 64'(o_busy), 64'h1);
            if (pokeBusy && k == 2) i_start = 1'b1;
            @(posedge CLK);
            @(negedge CLK);
            i_start = 1'b0;
        end
        edges = 2 * NV;
        while (!o_done && edges < 2 * NV + 10) begin
            @(posedge CLK);
            edges++;
            @(negedge CLK);
        end
        checkOutput({tag, "_done_edge"}, 64'(edges), 64'(2 * NV + 1));
        checkOutput({tag, "_done"}, 64'(o_done), 64'h1);
        checkOutput({tag, "_busy_end"}, 64'(o_busy), 64'h0);
        checkOutput({tag, "_err"}, 64'(o_err), 64'(expErr));
        checkOutput({tag, "_first"}, 64'(o_first), 64'(expFirst));
        checkOutput({tag, "_pass"}, 64'(o_pass), (expErr == 16'h0) ? 64'h1 : 64'h0);
        checkOutput({tag, "_hold_a"}, 64'(o_a), 64'(expA[NV-1]));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        faultMode = 0;
        i_start   = 1'b0;
        RSTb      = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkResetState("rst");
        RSTb = 1'b0;

        $display("[TB] ideal adder run with a start pulse while busy");
        applyStimulus("ideal", 0, 16'h0, 16'hFFFF, 1'b1);

        $display("[TB] carry-out inverted, restarted from DONE");
        applyStimulus("cinv", 2, 16'd5, 16'h0, 1'b0);

        $display("[TB] sum bit 0 stuck low");
        applyStimulus("s0", 1, 16'd3, 16'd1, 1'b0);

        $display("[TB] reset in the middle of a run");
        faultMode = 0;
        @(negedge CLK);
        i_start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        i_start = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        RSTb = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        checkResetState("midrst");
        RSTb = 1'b0;

        applyStimulus("after", 0, 16'h0, 16'hFFFF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
